seg7_history_display: RTL

- Downstream consumer of the 1-second nibble counter: takes its 4-bit `value` and drives a 4-digit multiplexed seven-segment display on the board.
- Keeps a 4-deep history of distinct values: each time the input changes, the new value shifts in as the rightmost digit.
- Scans the four digits with a refresh divider and decodes hex 0-F to segment patterns.
- Emits a one-cycle `changed` strobe for downstream logging.

---
 rtl/seg7_pkg.sv | 23 ++
 rtl/seg7_hex_decode.sv | 12 +
 rtl/seg7_history_display.sv | 112 +++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment lookup for the seven-segment display path.
package seg7_pkg;

  // Index of one of the four multiplexed digits (0 = rightmost).
  typedef logic [1:0] digit_idx_t;

  // One hex digit.
  typedef logic [3:0] nibble_t;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}, for hex 0..F.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Drive mask applied to a one-hot digit enable for the given digit.
  function automatic logic [3:0] digit_onehot(input digit_idx_t idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high seven-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  nibble_t    nibble,
  output logic [6:0] pattern
);

  // Pure table lookup; polarity is handled by the caller.
  assign pattern = SEG_HEX[nibble];

endmodule

// File: rtl/seg7_history_display.sv
// Four-digit multiplexed display of the last four distinct input nibbles.
// The newest value is shown on the rightmost digit; a one-cycle 'changed'
// strobe marks every new history entry.
module seg7_history_display
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 131072,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] value,
  output logic [6:0] segments,
  output logic       dp,
  output logic [3:0] anodes,
  output logic       changed
);

  localparam int              CW        = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]   SCAN_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [6:0]      SEG_MASK  = {7{ACTIVE_LOW}};
  localparam logic [3:0]      AN_MASK   = {4{ACTIVE_LOW}};

  nibble_t       value_q_reg;
  nibble_t       prev_reg;
  logic          primed_reg;
  logic [15:0]   history_reg;
  logic          changed_reg;
  logic [CW-1:0] scan_reg;
  digit_idx_t    idx_reg;

  nibble_t       digits [4];
  nibble_t       cur_nibble;
  logic [6:0]    cur_pattern;

  logic [6:0]    segments_reg;
  logic          dp_reg;
  logic [3:0]    anodes_reg;

  // Input register; deliberately not reset so priming sees the live input.
  always_ff @(posedge clock) begin
    value_q_reg <= value;
  end

  // Priming, change detection and history shift.
  always_ff @(posedge clock) begin
    if (reset) begin
      history_reg <= 16'h0000;
      prev_reg    <= 4'h0;
      primed_reg  <= 1'b0;
      changed_reg <= 1'b0;
    end else if (!primed_reg) begin
      // First cycle after reset only learns the current value.
      prev_reg    <= value_q_reg;
      primed_reg  <= 1'b1;
      changed_reg <= 1'b0;
    end else if (value_q_reg != prev_reg) begin
      history_reg <= {history_reg[11:0], value_q_reg};
      prev_reg    <= value_q_reg;
      changed_reg <= 1'b1;
    end else begin
      changed_reg <= 1'b0;
    end
  end

  // Refresh divider: each digit stays enabled for REFRESH_DIV cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      scan_reg <= '0;
      idx_reg  <= 2'd0;
    end else if (scan_reg == SCAN_LAST) begin
      scan_reg <= '0;
      idx_reg  <= idx_reg + 2'd1;
    end else begin
      scan_reg <= scan_reg + 1'b1;
    end
  end

  // Split the history into per-digit nibbles; digit 0 is the newest.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      assign digits[gi] = history_reg[gi*4 +: 4];
    end
  endgenerate

  assign cur_nibble = digits[idx_reg];

  seg7_hex_decode u_decode (
    .nibble  (cur_nibble),
    .pattern (cur_pattern)
  );

  // Registered drive stage with board polarity applied.
  always_ff @(posedge clock) begin
    if (reset) begin
      segments_reg <= SEG_HEX[0] ^ SEG_MASK;
      dp_reg       <= 1'b1 ^ ACTIVE_LOW;
      anodes_reg   <= digit_onehot(2'd0) ^ AN_MASK;
    end else begin
      segments_reg <= cur_pattern ^ SEG_MASK;
      dp_reg       <= (idx_reg == 2'd0) ^ ACTIVE_LOW;
      anodes_reg   <= digit_onehot(idx_reg) ^ AN_MASK;
    end
  end

  assign segments = segments_reg;
  assign dp       = dp_reg;
  assign anodes   = anodes_reg;
  assign changed  = changed_reg;

endmodule
